// File: rtl/tx_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tx_rr_packet_arbiter
//
// Purpose:
//   Shares one egress AXI-Stream interface between NUM_PORTS TX requesters.
//   The arbiter is round-robin and works on whole packets. Once a port is
//   granted, it keeps the output until its tlast beat is accepted. Every
//   output beat carries the source port index on tid. The block also keeps a
//   count of completed packets for each port.
//
// Ports:
//   aclk, areset          clock and asynchronous active-high reset
//   axis_tx_s_*           packed per-port input streams (port i = slice i)
//   axis_tx_m_*           single output stream, tid = granted port
//   port_enable           arbitration mask, looked at only when picking a grant
//   cnt_clear             synchronous clear of every packet counter
//   pkt_count             packed completed-packet counters (port i = slice i)
//   busy                  high while a packet is being passed through
// -----------------------------------------------------------------------------
module tx_rr_packet_arbiter #(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int AXIS_ID_WIDTH  = 2,
    parameter int NUM_PORTS      = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0]   axis_tx_s_tdata,
    input  logic [NUM_PORTS*AXIS_BUS_WIDTH/8-1:0] axis_tx_s_tkeep,
    input  logic [NUM_PORTS-1:0]                  axis_tx_s_tlast,
    input  logic [NUM_PORTS-1:0]                  axis_tx_s_tvalid,
    output logic [NUM_PORTS-1:0]                  axis_tx_s_tready,
    output logic [AXIS_BUS_WIDTH-1:0]             axis_tx_m_tdata,
    output logic [AXIS_BUS_WIDTH/8-1:0]           axis_tx_m_tkeep,
    output logic [AXIS_ID_WIDTH-1:0]              axis_tx_m_tid,
    output logic                                  axis_tx_m_tlast,
    output logic                                  axis_tx_m_tvalid,
    input  logic                                  axis_tx_m_tready,
    input  logic [NUM_PORTS-1:0]                  port_enable,
    input  logic                                  cnt_clear,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]        pkt_count,
    output logic                                  busy
);

    localparam int KEEP_WIDTH = AXIS_BUS_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [AXIS_ID_WIDTH-1:0]   grant_q, grant_d;
    logic [AXIS_ID_WIDTH-1:0]   last_grant_q, last_grant_d;

    logic [AXIS_BUS_WIDTH-1:0]  port_tdata [NUM_PORTS];
    logic [KEEP_WIDTH-1:0]      port_tkeep [NUM_PORTS];
    logic [AXIS_ID_WIDTH-1:0]   cand_idx   [NUM_PORTS];
    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS-1:0]       cnt_inc;
    logic [AXIS_ID_WIDTH-1:0]   sel_idx;
    logic                       sel_valid;
    logic                       in_pass;
    logic                       out_hs;

    // Unpack the flat input buses. cand_idx[k] is the port examined at
    // rotation offset k+1 from the last port that completed a packet.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_tdata[gi] = axis_tx_s_tdata[gi*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
            assign port_tkeep[gi] = axis_tx_s_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
            assign cand_idx[gi]   = AXIS_ID_WIDTH'((int'(last_grant_q) + gi + 1) % NUM_PORTS);
            assign axis_tx_s_tready[gi] = in_pass && (grant_q == AXIS_ID_WIDTH'(gi))
                                          && axis_tx_m_tready;
        end
    endgenerate

    assign req = axis_tx_s_tvalid & port_enable;

    // Scan from the highest offset down so the smallest offset that is
    // requesting wins. That offset is the port nearest after last_grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx[k];
            end
        end
    end

    // The output path is purely combinational from the granted port.
    // tvalid depends only on state and the source tvalid, so there is no
    // path from tready back into any tvalid.
    assign in_pass          = (state_q == PASS);
    assign busy             = in_pass;
    assign axis_tx_m_tvalid = in_pass && axis_tx_s_tvalid[grant_q];
    assign axis_tx_m_tdata  = port_tdata[grant_q];
    assign axis_tx_m_tkeep  = port_tkeep[grant_q];
    assign axis_tx_m_tlast  = axis_tx_s_tlast[grant_q];
    assign axis_tx_m_tid    = grant_q;
    assign out_hs           = axis_tx_m_tvalid && axis_tx_m_tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_inc      = '0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                // The grant stays locked through stalls and tvalid gaps.
                // Only the accepted tlast beat releases it.
                if (out_hs && axis_tx_m_tlast) begin
                    last_grant_d     = grant_q;
                    cnt_inc[grant_q] = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= AXIS_ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Per-port completed-packet counters. They wrap naturally, and a clear
    // takes precedence over an increment in the same cycle.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

            assign cnt_d = cnt_clear ? '0 : (cnt_q + CNT_WIDTH'(cnt_inc[gi]));

            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        end
    endgenerate

endmodule

// File: doc/tx_rr_packet_arbiter.md
Name: tx_rr_packet_arbiter

Overview:
- Shares the single egress network interface between NUM_PORTS AXI-Stream TX requesters.
- Arbitration is round-robin and packet-granular: once a port is granted, its whole packet (through tlast) passes before any other port is considered.
- Sits upstream of the NMU egress passthrough.
- Tags each output beat with the source port ID on tid.
- Provides a per-port enable mask and per-port completed-packet counters for software.

Parameters:
- AXIS_BUS_WIDTH, 64, stream data width in bits; must be a multiple of 8.
- AXIS_ID_WIDTH, 2, width of tid; NUM_PORTS must be <= 2^AXIS_ID_WIDTH.
- NUM_PORTS, 4, number of requesting streams; must be >= 2.
- CNT_WIDTH, 16, width of each per-port packet counter.

Ports:
- aclk  in  1  clock; all signals synchronous to it.
- areset  in  1  asynchronous, active-high reset.
- axis_tx_s_tdata  in  NUM_PORTS*AXIS_BUS_WIDTH  packed input data; port i occupies slice i.
- axis_tx_s_tkeep  in  NUM_PORTS*AXIS_BUS_WIDTH/8  packed input keep.
- axis_tx_s_tlast  in  NUM_PORTS  per-port last.
- axis_tx_s_tvalid  in  NUM_PORTS  per-port valid.
- axis_tx_s_tready  out  NUM_PORTS  per-port ready.
- axis_tx_m_tdata  out  AXIS_BUS_WIDTH  output data.
- axis_tx_m_tkeep  out  AXIS_BUS_WIDTH/8  output keep.
- axis_tx_m_tid  out  AXIS_ID_WIDTH  index of the granted port.
- axis_tx_m_tlast  out  1  output last.
- axis_tx_m_tvalid  out  1  output valid.
- axis_tx_m_tready  in  1  output ready.
- port_enable  in  NUM_PORTS  arbitration mask; sampled only when choosing a grant.
- cnt_clear  in  1  synchronous clear of all packet counters.
- pkt_count  out  NUM_PORTS*CNT_WIDTH  packed count of completed packets per port.
- busy  out  1  high while in state PASS.

Behaviour:
- Reset (async assert, synchronous deassert at the aclk edge) puts the block in:
  - state IDLE, grant=0, last_grant=NUM_PORTS-1 (so port 0 has first priority);
  - all pkt_count=0, busy=0;
  - axis_tx_m_tvalid=0, all axis_tx_s_tready=0.
- Output data path is combinational from the granted port while in PASS; there is no data register.
- axis_tx_m_tvalid = axis_tx_s_tvalid[grant] when in PASS, else 0.
- axis_tx_s_tready[i] = axis_tx_m_tready when in PASS and i==grant, else 0.
- tdata, tkeep and tlast are muxed from the granted port; tid=grant. These may hold any value when tvalid=0.
- State IDLE:
  - req = tvalid & port_enable.
  - If req is nonzero, select the first set bit scanning upward from last_grant+1 modulo NUM_PORTS.
  - Register that index into grant and go to PASS next cycle.
  - If req is zero, stay in IDLE.
  - Cost: exactly one bubble cycle per packet (IDLE to first beat).
- State PASS:
  - A handshake is tvalid && tready on the output.
  - A handshake with tlast=1: last_grant<=grant, pkt_count[grant]++, go to IDLE.
  - Otherwise stay in PASS; stalls on either side are held indefinitely.
- Masking mid-packet: clearing port_enable[grant] during PASS has no effect. The packet completes, and the port is excluded at the next IDLE.
- Valid drop mid-packet: the granted port deasserting tvalid does not release the grant; lock persists until tlast.
- Single-beat packets (tlast on first beat) are legal: one handshake, then IDLE.
- Counters:
  - Wrap modulo 2^CNT_WIDTH.
  - cnt_clear has priority over an increment in the same cycle; the result is 0.
- Fairness: with all ports continuously requesting, grants cycle 0,1,2,...,NUM_PORTS-1,0,...
- Reset during PASS forces output tvalid and input tready low immediately (asynchronous). The partial packet is abandoned, with no tlast generated.
- No combinational path from axis_tx_m_tready to any tvalid output.

Test Plan:
- Only port 2 valid, 3-beat packet, m_tready=1 → IDLE one cycle, then 3 consecutive beats with tid=2, tlast on beat 3; pkt_count[2]=1; busy high for 3 cycles.
- All 4 ports each holding two 2-beat packets, port_enable=4'hF → packet order by tid 0,1,2,3,0,1,2,3; one bubble cycle between packets; each pkt_count=2.
- Port 1 mid-packet, m_tready toggled 1,0,0,1 and port_enable[1] cleared at beat 2 → no beat lost or duplicated; packet completes; port 1 not granted afterwards while ports 0 and 3 request.
- Port 0 sends a single-beat packet with tlast=1, then port 0 sends again while port 3 requests → second grant goes to port 3 (last_grant=0 rotation).
- pkt_count[1]=16'hFFFF, one more port-1 packet → wraps to 0; cnt_clear asserted on the same cycle as a tlast handshake → count=0.
- areset pulsed during beat 2 of a 4-beat packet → m_tvalid and s_tready[grant] fall to 0 without waiting for aclk; after release state=IDLE, port 0 has priority, counters=0.
